// File: rtl/vending_ctrl_multi_pkg.sv
// Shared types and helpers for the multi-product vending controller.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    // Four products of 4-bit prices: p0=2, p1=3, p2=5, p3=7.
    localparam logic [15:0] DEFAULT_PRICES = 16'h7532;

    // Widest packed price vector the extract helper accepts.
    localparam int PRICE_VEC_W = 256;

    // Pull the price of product idx out of a packed vector of cw-bit fields.
    function automatic logic [31:0] price_of(input logic [PRICE_VEC_W-1:0] prices,
                                             input int cw, input int idx);
        logic [31:0] p;
        p = '0;
        for (int b = 0; b < 32; b++) begin
            if (b < cw && (idx * cw + b) < PRICE_VEC_W) begin
                p[b] = prices[idx * cw + b];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/vending_ctrl_multi_if.sv
// User-facing bus of the vending controller: request inputs and status outputs.
interface vending_ctrl_multi_if #(
    parameter int CREDIT_W = 4,
    parameter int PROD_W   = 2
);
    logic                tick;
    logic [1:0]          coin_val;
    logic [PROD_W-1:0]   sel;
    logic                buy;
    logic                cancel;
    logic [CREDIT_W-1:0] credit;
    logic                dispense;
    logic [PROD_W-1:0]   prod_out;
    logic                change_pulse;
    logic                coin_reject;
    logic                insufficient;
    logic                busy;

    modport master (
        output tick, coin_val, sel, buy, cancel,
        input  credit, dispense, prod_out, change_pulse, coin_reject, insufficient, busy
    );

    modport slave (
        input  tick, coin_val, sel, buy, cancel,
        output credit, dispense, prod_out, change_pulse, coin_reject, insufficient, busy
    );
endinterface

// File: rtl/vending_ctrl_multi_tick_timer.sv
// Loadable down-counter that only advances on tick; done when it has reached zero.
module vend_tick_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] count;

    // Load has priority; otherwise count down on enabled ticks and park at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && en && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);
endmodule

// File: rtl/vending_ctrl_multi.sv
// Multi-product vending controller advancing on an external tick strobe.
module vending_ctrl_multi
    import vending_pkg::*;
#(
    parameter int CREDIT_W      = 4,
    parameter int NUM_PROD      = 4,
    parameter int PROD_W        = 2,
    parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES = DEFAULT_PRICES,
    parameter int DISP_TICKS    = 3,
    parameter int TIMEOUT_TICKS = 15
) (
    input logic clk,
    input logic rst_n,
    vending_ctrl_multi_if.slave bus
);
    localparam int MAX_CREDIT = (1 << CREDIT_W) - 1;
    localparam int DISP_W     = $clog2(DISP_TICKS + 1);
    localparam int TO_W       = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
    // Timers are loaded with N-1 so the exit decision lands on the N-th tick.
    localparam logic [DISP_W-1:0] DISP_LOAD = DISP_W'(DISP_TICKS - 1);
    localparam logic [TO_W-1:0]   TO_LOAD   = (TIMEOUT_TICKS > 0) ? TO_W'(TIMEOUT_TICKS - 1) : '0;

    state_t              state, state_n;
    logic [CREDIT_W-1:0] credit_q, credit_n;
    logic [PROD_W-1:0]   prod_q, prod_n;
    logic                disp_q, disp_n;
    logic                chg_q, chg_n, rej_q, rej_n, ins_q, ins_n;
    logic                disp_load, disp_en, disp_done;
    logic                to_load, to_en, to_done;
    logic                coin_in, coin_fits, sel_ok;
    logic [CREDIT_W-1:0] price;

    assign coin_in   = (bus.coin_val != 2'd0);
    assign coin_fits = (int'(credit_q) + int'(bus.coin_val)) <= MAX_CREDIT;
    assign sel_ok    = int'(bus.sel) < NUM_PROD;
    assign price     = CREDIT_W'(price_of(PRICE_VEC_W'(PRICES), CREDIT_W, int'(bus.sel)));

    vend_tick_timer #(.W(DISP_W)) u_disp_timer (
        .clk(clk), .rst_n(rst_n), .tick(bus.tick), .load(disp_load),
        .en(disp_en), .load_val(DISP_LOAD), .done(disp_done)
    );

    vend_tick_timer #(.W(TO_W)) u_idle_timer (
        .clk(clk), .rst_n(rst_n), .tick(bus.tick), .load(to_load),
        .en(to_en), .load_val(TO_LOAD), .done(to_done)
    );

    // Next-state and next-output decode; nothing moves unless tick is high.
    always_comb begin
        state_n   = state;
        credit_n  = credit_q;
        prod_n    = prod_q;
        disp_n    = disp_q;
        chg_n     = 1'b0;
        rej_n     = 1'b0;
        ins_n     = 1'b0;
        disp_load = 1'b0;
        disp_en   = 1'b0;
        to_load   = 1'b0;
        to_en     = 1'b0;
        if (bus.tick) begin
            unique case (state)
                IDLE, CREDIT: begin
                    // Any user event restarts the idle timeout.
                    if (bus.cancel || bus.buy || coin_in) to_load = 1'b1;
                    if (bus.cancel) begin
                        rej_n = coin_in;
                        if (state == CREDIT) state_n = CHANGE;
                    end else if (bus.buy) begin
                        rej_n = coin_in;
                        if (sel_ok && credit_q >= price) begin
                            credit_n  = credit_q - price;
                            prod_n    = bus.sel;
                            disp_n    = 1'b1;
                            disp_load = 1'b1;
                            state_n   = DISPENSE;
                        end else begin
                            ins_n = 1'b1;
                        end
                    end else if (coin_in) begin
                        if (coin_fits) begin
                            credit_n = credit_q + CREDIT_W'(bus.coin_val);
                            state_n  = CREDIT;
                        end else begin
                            rej_n = 1'b1;
                        end
                    end else if (state == CREDIT && TIMEOUT_TICKS != 0) begin
                        if (to_done) begin
                            state_n = CHANGE;
                            to_load = 1'b1;
                        end else begin
                            to_en = 1'b1;
                        end
                    end
                end
                DISPENSE: begin
                    rej_n = coin_in;
                    if (disp_done) begin
                        disp_n  = 1'b0;
                        prod_n  = '0;
                        state_n = (credit_q != '0) ? CHANGE : IDLE;
                    end else begin
                        disp_en = 1'b1;
                    end
                end
                CHANGE: begin
                    rej_n = coin_in;
                    if (credit_q != '0) begin
                        chg_n    = 1'b1;
                        credit_n = credit_q - CREDIT_W'(1);
                    end
                    if (credit_q <= CREDIT_W'(1)) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State, credit and registered outputs; pulses self-clear on non-tick cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            credit_q <= '0;
            prod_q   <= '0;
            disp_q   <= 1'b0;
            chg_q    <= 1'b0;
            rej_q    <= 1'b0;
            ins_q    <= 1'b0;
        end else begin
            state    <= state_n;
            credit_q <= credit_n;
            prod_q   <= prod_n;
            disp_q   <= disp_n;
            chg_q    <= chg_n;
            rej_q    <= rej_n;
            ins_q    <= ins_n;
        end
    end

    assign bus.credit       = credit_q;
    assign bus.dispense     = disp_q;
    assign bus.prod_out     = prod_q;
    assign bus.change_pulse = chg_q;
    assign bus.coin_reject  = rej_q;
    assign bus.insufficient = ins_q;
    assign bus.busy         = (state == DISPENSE) || (state == CHANGE);
endmodule
